rv32_exec_core: RTL and testbench
=================================

# rv32_exec_core

Combinational RV32I decode/execute/memory slice of the single-cycle CPU. It takes the fetched instruction, the current PC and the two register-file read values. It produces register-file control, writeback data, branch/jump redirect and the PC target. It contains the only state in the slice, a word-organized data memory. It sits between fetch/regfile (upstream) and the regfile write port / fetch PC mux (downstream).

## Interface
- `MEM_WORDS`, default 256: data memory depth in 32-bit words, power of two.
- `clk` in 1: single clock; memory writes on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `instruction` in 32: current instruction.
- `pc` in 16: address of `instruction`.
- `rs1_data` in 32: regfile value of `rs1`.
- `rs2_data` in 32: regfile value of `rs2`.
- `rs1`, `rs2`, `rd` out 5: `instruction[19:15]`, `[24:20]`, `[11:7]`.
- `reg_wen` out 1: regfile write enable.
- `wb_data` out 32: regfile write data.
- `alu_result` out 32: ALU output (also the memory byte address).
- `branch_taken` out 1: branch comparison true (branch opcodes only).
- `next_pc_select` out 1: 1 = fetch loads `pc_target`, 0 = `pc+4`.
- `pc_target` out 16: redirect address.

## Operation
- Immediates are sign-extended to 32 bits:
  - I = `[31:20]`.
  - S = `{[31:25],[11:7]}`.
  - B = `{[31],[7],[30:25],[11:8],0}`.
  - J = `{[31],[19:12],[20],[30:21],0}`.
  - U = `{[31:12],12'b0}`.
- R-type 0110011: ADD/SUB (funct7[5]), SLL, SLT, SLTU, XOR, SRL/SRA (funct7[5]), OR, AND. Shift amount is `[4:0]` of the operand. `reg_wen`=1, `wb_data`=ALU.
- I-ALU 0010011: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI/SRAI (imm[10]). `reg_wen`=1.
- LW 0000011 (any funct3 treated as word):
  - `alu_result`=rs1+I.
  - `wb_data`=mem[`alu_result[log2(MEM_WORDS)+1:2]`].
  - `reg_wen`=1.
- SW 0100011: `alu_result`=rs1+S; writes `rs2_data` to the indexed word at the next rising `clk`; `reg_wen`=0.
- Memory addressing: address bits [1:0] are ignored and upper bits are truncated, so out-of-range addresses wrap.
- Branch 1100011: BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - `branch_taken` = comparison result.
  - `next_pc_select`=`branch_taken`.
  - `pc_target`=pc+B.
  - `reg_wen`=0.
  - funct3 010/011 → never taken.
- JAL 1101111: `next_pc_select`=1, `pc_target`=pc+J, `wb_data`=pc+4 (zero-extended), `reg_wen`=1.
- JALR 1100111: `next_pc_select`=1, `pc_target`=(rs1+I)[15:0] with bit 0 cleared, `wb_data`=pc+4, `reg_wen`=1.
- LUI 0110111: `wb_data`=U. AUIPC 0010111: `wb_data`=pc+U. Both set `reg_wen`=1.
- Any other opcode: `reg_wen`=0, no memory write, `next_pc_select`=0, `wb_data`=0, `alu_result`=0.
- `rd`=0: `reg_wen` may assert; the regfile ignores x0 writes.
- `pc_target` for non-redirecting instructions = pc+4.
- All PC arithmetic is mod 2^16.

## Timing
- All outputs are combinational from inputs and memory contents within the same cycle; zero latency.
- Memory read is asynchronous. Memory write is synchronous on the rising edge of `clk` when the opcode is SW and `rst`=0.
- Read-during-write to the same word returns the old data until the edge.
- `rst` asserted (asynchronous): all memory words clear to 0 immediately.
- While `rst` is high: `reg_wen`=0, `next_pc_select`=0, and memory writes are blocked. Other outputs still follow inputs.
- Reset deasserting mid-stream: the first edge after release may perform a write.

## Test plan
- Reset clears memory: write 0xDEADBEEF to word 4, assert `rst` → LW from addr 0x10 returns 0, `reg_wen`=0 during reset.
- ALU ops:
  - ADD rs1=5, rs2=7 → `wb_data`=12.
  - SUB 5-7 → 0xFFFFFFFE.
  - SRA 0x80000000>>4 → 0xF8000000.
  - SLTU 1 vs 0xFFFFFFFF → 1.
- Store/load: SW rs1=0x100, imm=8, rs2=0x12345678, then LW same address → `wb_data`=0x12345678. LW at 0x10A returns the same word as 0x108.
- Branches at pc=0x0040:
  - BEQ equal, imm=-8 → `next_pc_select`=1, `pc_target`=0x0038.
  - BLT rs1=1, rs2=-1 → not taken, `pc_target`=0x0044.
- Jumps at pc=0x0100:
  - JAL imm=0x20 → `pc_target`=0x0120, `wb_data`=0x104.
  - JALR rs1=0x203, imm=0 → `pc_target`=0x0202.
- LUI 0x12345 → `wb_data`=0x12345000. Illegal opcode 0x7F → `reg_wen`=0, no memory write, `next_pc_select`=0.

Source files
------------

// File: rtl/rv32_exec_core.sv
// RV32I decode/execute/memory slice for a single-cycle core: immediates, ALU, branch compare,
// next-PC selection and a word-organized data memory with asynchronous read and clear.
module rv32_exec_core #(
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_instruction,
    input  logic [15:0] i_pc,
    input  logic [31:0] i_rs1_data,
    input  logic [31:0] i_rs2_data,
    output logic [4:0]  o_rs1,
    output logic [4:0]  o_rs2,
    output logic [4:0]  o_rd,
    output logic        o_reg_wen,
    output logic [31:0] o_wb_data,
    output logic [31:0] o_alu_result,
    output logic        o_branch_taken,
    output logic        o_next_pc_select,
    output logic [15:0] o_pc_target
);

    localparam int unsigned AW = $clog2(MEM_WORDS);

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpJal    = 7'b1101111;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic        w_alt;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_u;
    logic [15:0] w_off_b;
    logic [15:0] w_off_j;

    assign w_opcode = i_instruction[6:0];
    assign w_funct3 = i_instruction[14:12];
    assign w_alt    = i_instruction[30];

    assign o_rs1 = i_instruction[19:15];
    assign o_rs2 = i_instruction[24:20];
    assign o_rd  = i_instruction[11:7];

    assign w_imm_i = {{20{i_instruction[31]}}, i_instruction[31:20]};
    assign w_imm_s = {{20{i_instruction[31]}}, i_instruction[31:25], i_instruction[11:7]};
    assign w_imm_u = {i_instruction[31:12], 12'b0};
    // PC arithmetic is 16-bit, so only the low 16 bits of the B/J offsets are ever needed.
    assign w_off_b = {{3{i_instruction[31]}}, i_instruction[31], i_instruction[7],
                      i_instruction[30:25], i_instruction[11:8], 1'b0};
    assign w_off_j = {i_instruction[15:12], i_instruction[20], i_instruction[30:21], 1'b0};

    // ALU shared by R-type and I-ALU
    logic        w_is_rtype;
    logic [31:0] w_alu_b;
    logic [4:0]  w_shamt;
    logic [31:0] w_alu_out;

    assign w_is_rtype = (w_opcode == OpReg);
    assign w_alu_b    = w_is_rtype ? i_rs2_data : w_imm_i;
    assign w_shamt    = w_alu_b[4:0];

    always_comb begin
        w_alu_out = '0;
        unique case (w_funct3)
            3'b000: w_alu_out = (w_is_rtype && w_alt) ? i_rs1_data - w_alu_b
                                                      : i_rs1_data + w_alu_b;
            3'b001: w_alu_out = i_rs1_data << w_shamt;
            3'b010: w_alu_out = {31'b0, $signed(i_rs1_data) < $signed(w_alu_b)};
            3'b011: w_alu_out = {31'b0, i_rs1_data < w_alu_b};
            3'b100: w_alu_out = i_rs1_data ^ w_alu_b;
            3'b101: w_alu_out = w_alt ? $unsigned($signed(i_rs1_data) >>> w_shamt)
                                      : i_rs1_data >> w_shamt;
            3'b110: w_alu_out = i_rs1_data | w_alu_b;
            3'b111: w_alu_out = i_rs1_data & w_alu_b;
            default: w_alu_out = '0;
        endcase
    end

    // Branch comparison; funct3 010/011 are not branches and never take
    logic w_cmp;

    always_comb begin
        w_cmp = 1'b0;
        unique case (w_funct3)
            3'b000:  w_cmp = (i_rs1_data == i_rs2_data);
            3'b001:  w_cmp = (i_rs1_data != i_rs2_data);
            3'b100:  w_cmp = ($signed(i_rs1_data) < $signed(i_rs2_data));
            3'b101:  w_cmp = ($signed(i_rs1_data) >= $signed(i_rs2_data));
            3'b110:  w_cmp = (i_rs1_data < i_rs2_data);
            3'b111:  w_cmp = (i_rs1_data >= i_rs2_data);
            default: w_cmp = 1'b0;
        endcase
    end

    // Address adder for loads, stores and JALR
    logic [31:0] w_addr_sum;
    logic [15:0] w_jalr_sum;
    logic [15:0] w_pc_plus4;
    logic [AW-1:0] w_mem_idx;

    assign w_addr_sum = i_rs1_data + ((w_opcode == OpStore) ? w_imm_s : w_imm_i);
    assign w_jalr_sum = i_rs1_data[15:0] + w_imm_i[15:0];
    assign w_pc_plus4 = i_pc + 16'd4;
    assign w_mem_idx  = w_addr_sum[AW+1:2];

    logic [31:0] r_mem [MEM_WORDS];
    logic [31:0] w_rdata;
    assign w_rdata = r_mem[w_mem_idx];

    // Main decode
    logic        w_wen;
    logic        w_redirect;
    logic        w_store;
    logic        w_taken;
    logic [31:0] w_wb;
    logic [31:0] w_alu;
    logic [15:0] w_target;

    always_comb begin
        w_wen      = 1'b0;
        w_redirect = 1'b0;
        w_store    = 1'b0;
        w_taken    = 1'b0;
        w_wb       = '0;
        w_alu      = '0;
        w_target   = w_pc_plus4;
        case (w_opcode)
            OpReg, OpImm: begin
                w_wen = 1'b1;
                w_alu = w_alu_out;
                w_wb  = w_alu_out;
            end
            OpLoad: begin
                w_wen = 1'b1;
                w_alu = w_addr_sum;
                w_wb  = w_rdata;
            end
            OpStore: begin
                w_store = 1'b1;
                w_alu   = w_addr_sum;
            end
            OpBranch: begin
                w_taken    = w_cmp;
                w_redirect = w_cmp;
                if (w_cmp) begin
                    w_target = i_pc + w_off_b;
                end
            end
            OpJal: begin
                w_wen      = 1'b1;
                w_redirect = 1'b1;
                w_target   = i_pc + w_off_j;
                w_wb       = {16'b0, w_pc_plus4};
            end
            OpJalr: begin
                w_wen      = 1'b1;
                w_redirect = 1'b1;
                w_target   = w_jalr_sum & 16'hFFFE;
                w_wb       = {16'b0, w_pc_plus4};
                w_alu      = w_addr_sum;
            end
            OpLui: begin
                w_wen = 1'b1;
                w_wb  = w_imm_u;
                w_alu = w_imm_u;
            end
            OpAuipc: begin
                w_wen = 1'b1;
                w_wb  = {16'b0, i_pc} + w_imm_u;
                w_alu = {16'b0, i_pc} + w_imm_u;
            end
            default: ;
        endcase
    end

    assign o_reg_wen        = w_wen & ~i_rst;
    assign o_next_pc_select = w_redirect & ~i_rst;
    assign o_wb_data        = w_wb;
    assign o_alu_result     = w_alu;
    assign o_branch_taken   = w_taken;
    assign o_pc_target      = w_target;

    // Reads see the old word until the edge; reset wipes the whole array at once
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_store) begin
            r_mem[w_mem_idx] <= i_rs2_data;
        end
    end

endmodule

// File: tb/tb_rv32_exec_core.sv
// Self-checking bench for rv32_exec_core: expectations queued at drive time, popped and compared
// one time unit later, away from the rising clock edge.
module tb_rv32_exec_core;

    logic        clk;
    logic        rst;
    logic [31:0] instruction;
    logic [15:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_wen;
    logic [31:0] wb_data;
    logic [31:0] alu_result;
    logic        branch_taken;
    logic        next_pc_select;
    logic [15:0] pc_target;

    int n_tests = 0;
    int n_fail  = 0;

    rv32_exec_core #(.MEM_WORDS(256)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_instruction    (instruction),
        .i_pc             (pc),
        .i_rs1_data       (rs1_data),
        .i_rs2_data       (rs2_data),
        .o_rs1            (rs1),
        .o_rs2            (rs2),
        .o_rd             (rd),
        .o_reg_wen        (reg_wen),
        .o_wb_data        (wb_data),
        .o_alu_result     (alu_result),
        .o_branch_taken   (branch_taken),
        .o_next_pc_select (next_pc_select),
        .o_pc_target      (pc_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        wen;
        logic        nps;
        logic        tk;
        logic [15:0] tgt;
        bit          cwb;
        logic [31:0] wb;
        bit          calu;
        logic [31:0] alu;
    } exp_t;

    exp_t sb[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, want);
        end
    endtask

    function automatic exp_t mk(input string tag, input logic wen, input logic nps,
                                input logic tk, input logic [15:0] tgt, input bit cwb,
                                input logic [31:0] wb, input bit calu, input logic [31:0] alu);
        exp_t e;
        e.tag = tag; e.wen = wen; e.nps = nps; e.tk = tk; e.tgt = tgt;
        e.cwb = cwb; e.wb = wb; e.calu = calu; e.alu = alu;
        return e;
    endfunction

    // Instruction encoders
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] s2,
                                          input logic [4:0] s1, input logic [2:0] f3,
                                          input logic [4:0] d);
        return {f7, s2, s1, f3, d, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [11:0] imm,
                                          input logic [4:0] s1, input logic [2:0] f3,
                                          input logic [4:0] d);
        return {imm, s1, f3, d, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] s2,
                                          input logic [4:0] s1);
        return {imm[11:5], s2, s1, 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] s2,
                                          input logic [4:0] s1, input logic [2:0] f3);
        return {imm[12], imm[10:5], s2, s1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] d);
        return {imm[20], imm[10:1], imm[11], imm[19:12], d, 7'b1101111};
    endfunction
    function automatic logic [31:0] enc_u(input logic [6:0] op, input logic [19:0] imm,
                                          input logic [4:0] d);
        return {imm, d, op};
    endfunction

    task automatic pop_and_check();
        exp_t e;
        if (sb.size() == 0) begin
            check_eq("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check_eq({e.tag, ".reg_wen"}, {31'b0, reg_wen}, {31'b0, e.wen});
        check_eq({e.tag, ".next_pc_select"}, {31'b0, next_pc_select}, {31'b0, e.nps});
        check_eq({e.tag, ".branch_taken"}, {31'b0, branch_taken}, {31'b0, e.tk});
        check_eq({e.tag, ".pc_target"}, {16'b0, pc_target}, {16'b0, e.tgt});
        if (e.cwb)  check_eq({e.tag, ".wb_data"}, wb_data, e.wb);
        if (e.calu) check_eq({e.tag, ".alu_result"}, alu_result, e.alu);
    endtask

    // Inputs (including reset) change together at the falling edge, checked 1 unit later
    task automatic drive(input logic r, input logic [31:0] ins, input logic [15:0] p,
                         input logic [31:0] a, input logic [31:0] b, input exp_t e);
        @(negedge clk);
        rst         = r;
        instruction = ins;
        pc          = p;
        rs1_data    = a;
        rs2_data    = b;
        sb.push_back(e);
        #1;
        pop_and_check();
    endtask

    function automatic logic [31:0] model_alu(input int k, input logic [31:0] a,
                                              input logic [31:0] b);
        case (k)
            0: return a + b;
            1: return a - b;
            2: return a ^ b;
            3: return a | b;
            4: return a & b;
            default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    localparam logic [6:0] OpLoad = 7'b0000011;
    localparam logic [6:0] OpImm  = 7'b0010011;
    localparam logic [6:0] OpJalr = 7'b1100111;

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f3s [6];
        logic [6:0]  f7s [6];
        f3s = '{3'b000, 3'b000, 3'b100, 3'b110, 3'b111, 3'b010};
        f7s = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00};

        rst = 1'b1; instruction = '0; pc = '0; rs1_data = '0; rs2_data = '0;
        repeat (2) @(negedge clk);

        // Reset gating of control outputs while data outputs keep following inputs
        drive(1'b1, enc_j(21'h20, 5'd1), 16'h0100, 0, 0,
              mk("rst_jal", 0, 0, 0, 16'h0120, 1, 32'h104, 0, 0));
        drive(1'b0, enc_s(12'h000, 5'd2, 5'd1), 16'h0000, 32'h10, 32'hDEADBEEF,
              mk("sw_dead", 0, 0, 0, 16'h0004, 0, 0, 1, 32'h10));
        drive(1'b0, enc_i(OpLoad, 12'h000, 5'd1, 3'b010, 5'd3), 16'h0000, 32'h10, 0,
              mk("lw_dead", 1, 0, 0, 16'h0004, 1, 32'hDEADBEEF, 1, 32'h10));
        drive(1'b1, enc_i(OpLoad, 12'h000, 5'd1, 3'b010, 5'd3), 16'h0000, 32'h10, 0,
              mk("lw_in_rst", 0, 0, 0, 16'h0004, 1, 32'h0, 1, 32'h10));
        drive(1'b1, enc_s(12'h000, 5'd2, 5'd1), 16'h0000, 32'h10, 32'h0000CAFE,
              mk("sw_blocked", 0, 0, 0, 16'h0004, 0, 0, 1, 32'h10));
        drive(1'b0, enc_i(OpLoad, 12'h000, 5'd1, 3'b010, 5'd3), 16'h0000, 32'h10, 0,
              mk("lw_blocked", 1, 0, 0, 16'h0004, 1, 32'h0, 1, 32'h10));

        // Store/load, byte-offset ignore, wrap and negative offset
        drive(1'b0, enc_s(12'h008, 5'd2, 5'd1), 16'h0000, 32'h100, 32'h12345678,
              mk("sw_108", 0, 0, 0, 16'h0004, 0, 0, 1, 32'h108));
        drive(1'b0, enc_i(OpLoad, 12'h008, 5'd1, 3'b010, 5'd3), 16'h0000, 32'h100, 0,
              mk("lw_108", 1, 0, 0, 16'h0004, 1, 32'h12345678, 1, 32'h108));
        drive(1'b0, enc_i(OpLoad, 12'h000, 5'd1, 3'b000, 5'd3), 16'h0000, 32'h10A, 0,
              mk("lw_10a", 1, 0, 0, 16'h0004, 1, 32'h12345678, 1, 32'h10A));
        drive(1'b0, enc_i(OpLoad, 12'h008, 5'd1, 3'b010, 5'd3), 16'h0000, 32'h500, 0,
              mk("lw_wrap", 1, 0, 0, 16'h0004, 1, 32'h12345678, 1, 32'h508));
        drive(1'b0, enc_i(OpLoad, 12'hFF8, 5'd1, 3'b010, 5'd3), 16'h0000, 32'h110, 0,
              mk("lw_negoff", 1, 0, 0, 16'h0004, 1, 32'h12345678, 1, 32'h108));

        // ALU
        drive(1'b0, enc_r(7'h00, 5'd3, 5'd2, 3'b000, 5'd1), 16'h0000, 5, 7,
              mk("add", 1, 0, 0, 16'h0004, 1, 32'd12, 1, 32'd12));
        check_eq("field_rs1", {27'b0, rs1}, 32'd2);
        check_eq("field_rs2", {27'b0, rs2}, 32'd3);
        check_eq("field_rd", {27'b0, rd}, 32'd1);
        drive(1'b0, enc_r(7'h20, 5'd3, 5'd2, 3'b000, 5'd1), 16'h0000, 5, 7,
              mk("sub", 1, 0, 0, 16'h0004, 1, 32'hFFFFFFFE, 0, 0));
        drive(1'b0, enc_r(7'h20, 5'd3, 5'd2, 3'b101, 5'd1), 16'h0000, 32'h80000000, 4,
              mk("sra", 1, 0, 0, 16'h0004, 1, 32'hF8000000, 0, 0));
        drive(1'b0, enc_r(7'h00, 5'd3, 5'd2, 3'b101, 5'd1), 16'h0000, 32'h80000000, 4,
              mk("srl", 1, 0, 0, 16'h0004, 1, 32'h08000000, 0, 0));
        drive(1'b0, enc_r(7'h00, 5'd3, 5'd2, 3'b011, 5'd1), 16'h0000, 1, 32'hFFFFFFFF,
              mk("sltu", 1, 0, 0, 16'h0004, 1, 32'd1, 0, 0));
        drive(1'b0, enc_r(7'h00, 5'd3, 5'd2, 3'b010, 5'd1), 16'h0000, 1, 32'hFFFFFFFF,
              mk("slt", 1, 0, 0, 16'h0004, 1, 32'd0, 0, 0));
        drive(1'b0, enc_r(7'h00, 5'd3, 5'd2, 3'b001, 5'd1), 16'h0000, 3, 32'h21,
              mk("sll_shamt5", 1, 0, 0, 16'h0004, 1, 32'd6, 0, 0));
        drive(1'b0, enc_i(OpImm, 12'h404, 5'd2, 3'b101, 5'd1), 16'h0000, 32'h80000000, 0,
              mk("srai", 1, 0, 0, 16'h0004, 1, 32'hF8000000, 0, 0));
        drive(1'b0, enc_i(OpImm, 12'h01F, 5'd2, 3'b001, 5'd1), 16'h0000, 1, 0,
              mk("slli", 1, 0, 0, 16'h0004, 1, 32'h80000000, 0, 0));
        drive(1'b0, enc_i(OpImm, 12'hFFF, 5'd2, 3'b100, 5'd1), 16'h0000, 32'hFF, 0,
              mk("xori", 1, 0, 0, 16'h0004, 1, 32'hFFFFFF00, 0, 0));
        drive(1'b0, enc_i(OpImm, 12'hFFF, 5'd2, 3'b011, 5'd1), 16'h0000, 5, 0,
              mk("sltiu", 1, 0, 0, 16'h0004, 1, 32'd1, 0, 0));

        // Branches at pc 0x0040
        drive(1'b0, enc_b(13'h1FF8, 5'd3, 5'd2, 3'b000), 16'h0040, 5, 5,
              mk("beq_taken", 0, 1, 1, 16'h0038, 0, 0, 0, 0));
        drive(1'b0, enc_b(13'h0010, 5'd3, 5'd2, 3'b100), 16'h0040, 1, 32'hFFFFFFFF,
              mk("blt_not", 0, 0, 0, 16'h0044, 0, 0, 0, 0));
        drive(1'b0, enc_b(13'h0010, 5'd3, 5'd2, 3'b001), 16'h0040, 5, 5,
              mk("bne_not", 0, 0, 0, 16'h0044, 0, 0, 0, 0));
        drive(1'b0, enc_b(13'h0010, 5'd3, 5'd2, 3'b110), 16'h0040, 1, 32'hFFFFFFFF,
              mk("bltu_taken", 0, 1, 1, 16'h0050, 0, 0, 0, 0));
        drive(1'b0, enc_b(13'h0010, 5'd3, 5'd2, 3'b101), 16'h0040, 1, 32'hFFFFFFFF,
              mk("bge_taken", 0, 1, 1, 16'h0050, 0, 0, 0, 0));
        drive(1'b0, enc_b(13'h0010, 5'd3, 5'd2, 3'b111), 16'h0040, 1, 32'hFFFFFFFF,
              mk("bgeu_not", 0, 0, 0, 16'h0044, 0, 0, 0, 0));
        drive(1'b0, enc_b(13'h0010, 5'd3, 5'd2, 3'b010), 16'h0040, 5, 5,
              mk("b010_never", 0, 0, 0, 16'h0044, 0, 0, 0, 0));

        // Jumps, upper immediates
        drive(1'b0, enc_j(21'h20, 5'd1), 16'h0100, 0, 0,
              mk("jal", 1, 1, 0, 16'h0120, 1, 32'h104, 0, 0));
        drive(1'b0, enc_j(21'h8, 5'd1), 16'hFFFC, 0, 0,
              mk("jal_wrap", 1, 1, 0, 16'h0004, 1, 32'h0, 0, 0));
        drive(1'b0, enc_i(OpJalr, 12'h000, 5'd2, 3'b000, 5'd1), 16'h0100, 32'h203, 0,
              mk("jalr", 1, 1, 0, 16'h0202, 1, 32'h104, 0, 0));
        drive(1'b0, enc_u(7'b0110111, 20'h12345, 5'd1), 16'h0000, 0, 0,
              mk("lui", 1, 0, 0, 16'h0004, 1, 32'h12345000, 0, 0));
        drive(1'b0, enc_u(7'b0010111, 20'h00001, 5'd1), 16'h1000, 0, 0,
              mk("auipc", 1, 0, 0, 16'h1004, 1, 32'h2000, 0, 0));

        // Illegal opcode: no writeback, no redirect, no memory write across the edge
        drive(1'b0, 32'hFFFFFFFF, 16'h0200, 32'h108, 32'hA5A5A5A5,
              mk("illegal_ff", 0, 0, 0, 16'h0204, 1, 32'h0, 1, 32'h0));
        drive(1'b0, 32'h0000007F, 16'h0200, 32'h0, 32'hA5A5A5A5,
              mk("illegal_7f", 0, 0, 0, 16'h0204, 1, 32'h0, 1, 32'h0));
        drive(1'b0, enc_i(OpLoad, 12'h008, 5'd1, 3'b010, 5'd3), 16'h0000, 32'h100, 0,
              mk("lw_after_illegal", 1, 0, 0, 16'h0004, 1, 32'h12345678, 1, 32'h108));
        drive(1'b0, enc_i(OpLoad, 12'h000, 5'd1, 3'b010, 5'd3), 16'h0000, 32'h0, 0,
              mk("lw0_after_illegal", 1, 0, 0, 16'h0004, 1, 32'h0, 1, 32'h0));

        // Random R-type against a reference model
        for (int i = 0; i < 12; i++) begin
            int k;
            k = i % 6;
            a = $urandom;
            b = $urandom;
            drive(1'b0, enc_r(f7s[k], 5'd3, 5'd2, f3s[k], 5'd4), 16'h0000, a, b,
                  mk($sformatf("rand%0d", i), 1, 0, 0, 16'h0004, 1, model_alu(k, a, b), 1,
                     model_alu(k, a, b)));
        end

        if (sb.size() != 0) check_eq("scoreboard_leftover", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
